// File: rtl/clk_lock_monitor.sv
// clk_lock_monitor: qualifies asynchronous lock inputs and reports lock status, loss history and LED drive
module clk_lock_monitor #(
  parameter int NUM_CH        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HB_W          = 27,
  parameter int SEL_W         = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   lock_in,
  input  logic                sticky_clr,
  input  logic [1:0]          led_mode,
  input  logic [SEL_W-1:0]    led_sel,
  output logic [NUM_CH-1:0]   ch_stable,
  output logic                all_locked,
  output logic [NUM_CH-1:0]   lol_sticky,
  output logic [8*NUM_CH-1:0] lol_count,
  output logic                heartbeat,
  output logic [7:0]          leds
);
  localparam int QW = $clog2(STABLE_CYCLES);
  typedef enum logic [1:0] {LOST, QUAL, LOCKED} state_e;
  logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
  logic [SYNC_STAGES-1:0] sync_d [NUM_CH];
  state_e                 state_q [NUM_CH];
  state_e                 state_d [NUM_CH];
  logic [QW-1:0]          qcnt_q [NUM_CH];
  logic [QW-1:0]          qcnt_d [NUM_CH];
  logic [7:0]             cnt_q [NUM_CH];
  logic [7:0]             cnt_d [NUM_CH];
  logic [NUM_CH-1:0]      sticky_q, sticky_d, s;
  logic                   all_locked_q, all_locked_d;
  logic [HB_W-1:0]        hb_q, hb_d;
  logic [7:0]             leds_q, leds_d, sel_cnt;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign s[g]                 = sync_q[g][SYNC_STAGES-1];
    assign ch_stable[g]         = (state_q[g] == LOCKED);
    assign lol_count[8*g +: 8]  = cnt_q[g];
  end
  assign lol_sticky = sticky_q;
  assign all_locked = all_locked_q;
  assign heartbeat  = hb_q[HB_W-1];
  assign leds       = leds_q;
  // Per-channel synchroniser shift, qualification FSM and loss bookkeeping; a loss beats a coincident clear
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sync_d[i]   = {sync_q[i][SYNC_STAGES-2:0], lock_in[i]};
      state_d[i]  = state_q[i];
      qcnt_d[i]   = qcnt_q[i];
      sticky_d[i] = sticky_clr ? 1'b0 : sticky_q[i];
      cnt_d[i]    = sticky_clr ? 8'd0 : cnt_q[i];
      case (state_q[i])
        LOST: if (s[i]) begin
          state_d[i] = QUAL;
          qcnt_d[i]  = '0;
        end
        QUAL: if (!s[i]) state_d[i] = LOST;
              else if (qcnt_q[i] == QW'(STABLE_CYCLES - 1)) state_d[i] = LOCKED;
              else qcnt_d[i] = qcnt_q[i] + 1'b1;
        LOCKED: if (!s[i]) begin
          state_d[i]  = LOST;
          sticky_d[i] = 1'b1;
          cnt_d[i]    = sticky_clr ? 8'd1 : (cnt_q[i] == 8'hFF ? cnt_q[i] : cnt_q[i] + 8'd1);
        end
        default: state_d[i] = LOST;
      endcase
    end
  end
  // Aggregate lock, heartbeat and LED mux; out-of-range channel select shows zero
  always_comb begin
    all_locked_d = &ch_stable;
    hb_d         = hb_q + 1'b1;
    sel_cnt      = 8'h00;
    for (int i = 0; i < NUM_CH; i++)
      if (led_sel == SEL_W'(i)) sel_cnt = cnt_q[i];
    leds_d = led_mode == 2'd0 ? ({heartbeat, 7'b0} | (8'(ch_stable) << 1) | {7'b0, all_locked_q}) :
             led_mode == 2'd1 ? ({heartbeat, 7'b0} | 8'(sticky_q)) :
             led_mode == 2'd2 ? sel_cnt : 8'hFF;
  end
  // State registers with asynchronous clear back to LOST
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i]  <= '0;
        state_q[i] <= LOST;
        qcnt_q[i]  <= '0;
        cnt_q[i]   <= '0;
      end
      sticky_q     <= '0;
      all_locked_q <= 1'b0;
      hb_q         <= '0;
      leds_q       <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        sync_q[i]  <= sync_d[i];
        state_q[i] <= state_d[i];
        qcnt_q[i]  <= qcnt_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      sticky_q     <= sticky_d;
      all_locked_q <= all_locked_d;
      hb_q         <= hb_d;
      leds_q       <= leds_d;
    end
  end
endmodule

// File: tb/tb_clk_lock_monitor.sv
// tb_clk_lock_monitor: directed checks of qualification, loss tracking, LEDs and async reset
module tb_clk_lock_monitor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  lock_in = 4'h0;
  logic        sticky_clr = 1'b0;
  logic [1:0]  led_mode = 2'd0;
  logic [2:0]  led_sel = 3'd0;
  logic [3:0]  ch_stable, lol_sticky;
  logic        all_locked, heartbeat;
  logic [31:0] lol_count;
  logic [7:0]  leds;
  int          tests = 0;
  int          fails = 0;

  clk_lock_monitor #(.NUM_CH(4), .SYNC_STAGES(2), .STABLE_CYCLES(16), .HB_W(6), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .lock_in(lock_in), .sticky_clr(sticky_clr),
    .led_mode(led_mode), .led_sel(led_sel), .ch_stable(ch_stable), .all_locked(all_locked),
    .lol_sticky(lol_sticky), .lol_count(lol_count), .heartbeat(heartbeat), .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_and_qualify();
    lock_in = 4'hF;
    tick();
    tick();
    tests++; if ({ch_stable, all_locked, lol_sticky, lol_count, heartbeat, leds} !== 50'd0) begin fails++; $display("FAIL reset_state got %h required 0", {ch_stable, all_locked, lol_sticky, lol_count, heartbeat, leds}); end
    rst_n = 1'b1;
    repeat (18) tick();
    tests++; if (ch_stable !== 4'h0) begin fails++; $display("FAIL qual_early got %h required 0", ch_stable); end
    tick();
    tests++; if (ch_stable !== 4'hF) begin fails++; $display("FAIL qual_rise got %h required f", ch_stable); end
    tests++; if (all_locked !== 1'b0) begin fails++; $display("FAIL all_locked_early got %b required 0", all_locked); end
    tick();
    tests++; if (all_locked !== 1'b1) begin fails++; $display("FAIL all_locked_rise got %b required 1", all_locked); end
    tests++; if (lol_sticky !== 4'h0) begin fails++; $display("FAIL sticky_after_qual got %h required 0", lol_sticky); end
  endtask

  task automatic test_qual_glitch();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    lock_in = 4'hF;
    repeat (11) tick();
    lock_in[1] = 1'b0;
    repeat (5) tick();
    lock_in[1] = 1'b1;
    repeat (3) tick();
    tests++; if (ch_stable !== 4'hD) begin fails++; $display("FAIL glitch_stable got %h required d", ch_stable); end
    tests++; if (lol_sticky !== 4'h0 || lol_count !== 32'h0) begin fails++; $display("FAIL glitch_no_sticky got %h/%h required 0/0", lol_sticky, lol_count); end
    repeat (15) tick();
    tests++; if (ch_stable !== 4'hD) begin fails++; $display("FAIL glitch_requal_early got %h required d", ch_stable); end
    tick();
    tests++; if (ch_stable !== 4'hF) begin fails++; $display("FAIL glitch_requal got %h required f", ch_stable); end
    tick();
    tests++; if (all_locked !== 1'b1) begin fails++; $display("FAIL glitch_all_locked got %b required 1", all_locked); end
  endtask

  task automatic test_loss();
    int n = 0;
    int cnt = 0;
    bit seen = 0;
    lock_in[2] = 1'b0;
    for (int i = 1; i <= 6 && !seen; i++) begin
      tick();
      cnt = i;
      if (i == 3) lock_in[2] = 1'b1;
      if (!ch_stable[2]) begin seen = 1; n = i; end
    end
    tests++; if (!seen || n < 3 || n > 4) begin fails++; $display("FAIL loss_latency got %0d edges required 3..4", n); end
    tests++; if (all_locked !== 1'b1) begin fails++; $display("FAIL loss_all_locked_hold got %b required 1", all_locked); end
    tick();
    cnt++;
    tests++; if (all_locked !== 1'b0) begin fails++; $display("FAIL loss_all_locked_fall got %b required 0", all_locked); end
    tests++; if (lol_sticky !== 4'h4 || lol_count !== 32'h0001_0000) begin fails++; $display("FAIL loss_record got %h/%h required 4/00010000", lol_sticky, lol_count); end
    while (cnt < 21) begin tick(); cnt++; end
    tests++; if (ch_stable[2] !== 1'b0) begin fails++; $display("FAIL loss_requal_early got %b required 0", ch_stable[2]); end
    tick();
    tests++; if (ch_stable[2] !== 1'b1) begin fails++; $display("FAIL loss_requal got %b required 1", ch_stable[2]); end
  endtask

  task automatic test_saturate_and_clear();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    tests++; if (lol_sticky !== 4'h0 || lol_count !== 32'h0) begin fails++; $display("FAIL first_clear got %h/%h required 0/0", lol_sticky, lol_count); end
    for (int k = 0; k < 300; k++) begin
      lock_in[0] = 1'b0;
      repeat (3) tick();
      lock_in[0] = 1'b1;
      repeat (20) tick();
    end
    tests++; if (lol_count !== 32'h0000_00FF || lol_sticky !== 4'h1) begin fails++; $display("FAIL saturate got %h/%h required 000000ff/1", lol_count, lol_sticky); end
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    tests++; if (lol_sticky !== 4'h0 || lol_count !== 32'h0) begin fails++; $display("FAIL clear got %h/%h required 0/0", lol_sticky, lol_count); end
    lock_in[0] = 1'b0;
    tick();
    tick();
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    tests++; if (lol_sticky !== 4'h1 || lol_count !== 32'h0000_0001) begin fails++; $display("FAIL clear_vs_loss got %h/%h required 1/00000001", lol_sticky, lol_count); end
    lock_in[0] = 1'b1;
    repeat (20) tick();
    tests++; if (ch_stable !== 4'hF) begin fails++; $display("FAIL requal_after_clear got %h required f", ch_stable); end
  endtask

  task automatic test_leds();
    logic prev;
    int n = 0;
    bit found = 0;
    led_mode = 2'd0;
    lock_in[2] = 1'b0;
    repeat (5) tick();
    tests++; if (ch_stable !== 4'hB || all_locked !== 1'b0) begin fails++; $display("FAIL led_setup got %h/%b required b/0", ch_stable, all_locked); end
    tests++; if (leds[6:0] !== 7'b0010110) begin fails++; $display("FAIL led_mode0 got %b required 0010110", leds[6:0]); end
    led_mode = 2'd1;
    tick();
    tests++; if (leds[6:0] !== 7'h05) begin fails++; $display("FAIL led_mode1 got %h required 05", leds[6:0]); end
    led_mode = 2'd2;
    led_sel = 3'd0;
    tick();
    tests++; if (leds !== 8'h01) begin fails++; $display("FAIL led_mode2_sel0 got %h required 01", leds); end
    led_sel = 3'd5;
    tick();
    tests++; if (leds !== 8'h00) begin fails++; $display("FAIL led_mode2_sel5 got %h required 00", leds); end
    led_mode = 2'd3;
    tick();
    tests++; if (leds !== 8'hFF) begin fails++; $display("FAIL led_mode3 got %h required ff", leds); end
    prev = heartbeat;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (heartbeat !== prev) found = 1;
    end
    prev = heartbeat;
    for (int i = 0; i < 40 && heartbeat === prev; i++) begin
      tick();
      n++;
    end
    tests++; if (!found || n != 32) begin fails++; $display("FAIL heartbeat_period got %0d required 32", n); end
    led_mode = 2'd0;
    lock_in[2] = 1'b1;
    repeat (22) tick();
  endtask

  task automatic test_async_reset();
    tests++; if (ch_stable !== 4'hF) begin fails++; $display("FAIL pre_reset_locked got %h required f", ch_stable); end
    #3 rst_n = 1'b0;
    #1;
    tests++; if ({ch_stable, all_locked, lol_sticky, lol_count, heartbeat, leds} !== 50'd0) begin fails++; $display("FAIL async_reset got %h required 0", {ch_stable, all_locked, lol_sticky, lol_count, heartbeat, leds}); end
    tick();
    tick();
    rst_n = 1'b1;
    repeat (18) tick();
    tests++; if (ch_stable !== 4'h0) begin fails++; $display("FAIL reset_requal_early got %h required 0", ch_stable); end
    tick();
    tests++; if (ch_stable !== 4'hF) begin fails++; $display("FAIL reset_requal got %h required f", ch_stable); end
  endtask

  initial begin
    test_reset_and_qualify();
    test_qual_glitch();
    test_loss();
    test_saturate_and_clear();
    test_leds();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/clk_lock_monitor.md
Name: clk_lock_monitor

Overview:
- Parametrised successor to the board clock/lock status block.
- Qualifies NUM_CH asynchronous lock/ready inputs (MMCM locked, DDR calib done, PLL locked, ...) with synchroniser plus stability timer.
- Produces a registered aggregate all_locked, per-channel loss-of-lock sticky flags and saturating counters, and a mode-selectable LED bus with heartbeat.
- Sits in the board-support layer, ahead of reset sequencing and the LED header.

Parameters:
NUM_CH, 4, number of monitored lock inputs, 1..6
SYNC_STAGES, 2, synchroniser flops per input, 2..4
STABLE_CYCLES, 1024, cycles input must stay high before channel qualifies, >=2
HB_W, 27, heartbeat counter width; heartbeat = MSB
SEL_W, 3, width of led_sel, >= clog2(NUM_CH)

Ports:
clk  in  1  monitor clock, all logic single domain
rst_n  in  1  asynchronous active-low reset
lock_in  in  NUM_CH  raw asynchronous lock/ready inputs
sticky_clr  in  1  synchronous pulse; clears lol_sticky and lol_count
led_mode  in  2  LED display select
led_sel  in  SEL_W  channel whose lol_count is shown in mode 2
ch_stable  out  NUM_CH  per-channel qualified lock
all_locked  out  1  registered AND of ch_stable
lol_sticky  out  NUM_CH  loss-of-lock seen since last clear
lol_count  out  8*NUM_CH  per-channel loss count, channel i at [8i+7:8i]
heartbeat  out  1  heartbeat counter MSB
leds  out  8  registered LED drive

Behaviour:
- Reset (rst_n low, async): synchronisers, state, counters, all outputs = 0; every channel FSM in LOST.
- Sync: lock_in[i] passes through SYNC_STAGES flops -> s[i]. No other logic touches raw lock_in.
- Per-channel FSM, 3 states:
  - LOST: s=1 -> QUAL, qcnt<=0; else stay.
  - QUAL: s=0 -> LOST (no sticky, no count); qcnt==STABLE_CYCLES-1 -> LOCKED; else qcnt+1.
  - LOCKED: s=0 -> LOST; set lol_sticky[i]; lol_count[i] +1, saturating at 255.
- qcnt width: clog2(STABLE_CYCLES).
- ch_stable[i] = (state==LOCKED), registered.
- Latency, lock_in held high from edge E1 (first edge sampling high): ch_stable rises after edge E1+SYNC_STAGES+STABLE_CYCLES. all_locked follows one edge later.
- Loss latency: ch_stable falls SYNC_STAGES+1 edges after the first edge sampling lock_in low. all_locked falls one edge after that.
- A glitch shorter than one clock may be missed; not an error.
- sticky_clr, same edge for all channels: lol_sticky<=0, lol_count<=0.
- sticky_clr coincident with a LOCKED->LOST transition on channel i: set wins, lol_sticky[i]=1, lol_count[i]=1.
- Heartbeat: free-running HB_W counter, wraps all-ones -> 0. Unaffected by sticky_clr.
- leds, registered, one edge after inputs change:
  - mode 0: leds[0]=all_locked, leds[NUM_CH:1]=ch_stable, leds[7]=heartbeat, rest 0.
  - mode 1: leds[NUM_CH-1:0]=lol_sticky, leds[7]=heartbeat, rest 0.
  - mode 2: lol_count[led_sel]; led_sel>=NUM_CH -> 8'h00.
  - mode 3: 8'hFF (lamp test).
- Reset mid-QUAL or mid-LOCKED: immediate return to LOST, counts and stickies lost.

Test Plan (NUM_CH=4, SYNC_STAGES=2, STABLE_CYCLES=16, HB_W=6):
1. Reset release, lock_in=4'hF at edge E1 -> ch_stable=4'hF after edge E1+18, all_locked=1 after E1+19, lol_sticky=0.
2. Channel 1 drops low for 5 cycles during QUAL at qcnt=10 -> returns to LOST, no sticky. On re-rise, full 16-cycle qualification restarts.
3. All locked, lock_in[2] low for 3 cycles -> ch_stable[2]=0 and lol_sticky=4'h4, lol_count[2]=1. all_locked drops one edge after ch_stable[2]. Requalifies 18 edges after lock_in[2] returns high.
4. 300 loss/requalify cycles on channel 0 -> lol_count[0]=255 and holds. sticky_clr pulse -> 0. sticky_clr coincident with a new loss -> lol_count[0]=1, lol_sticky[0]=1.
5. LED modes with ch_stable=4'hB, all_locked=0:
   - mode 0 -> leds[4:0]=5'b10110.
   - mode 2 with led_sel=5 -> 8'h00.
   - mode 3 -> 8'hFF.
   - heartbeat toggles every 32 cycles.
6. rst_n asserted asynchronously mid-LOCKED (between edges) -> all outputs 0 immediately. After release with lock_in high, qualification restarts from LOST.
